pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and optional skid buffer. Generic replacement for the fixed per-stage latches between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is an opaque DATA_W-bit vector; each instantiating stage packs its fields (pc, ALU result, read data, rd address, control bits) into it. Adds stall, bubble and flush behaviour, and full reset of every bit.

## Interface
- DATA_W, 102, payload width (default MEM/WB: pc 32 + ALU result 32 + read data 32 + rd 5 + WB 1)
- RESET_DATA, '0, value loaded into every data register at reset and on flush
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- flush_i  input  1  synchronous flush; discards all held beats
- in_valid_i  input  1  upstream beat present
- in_ready_o  output  1  stage can accept a beat
- in_data_i  input  DATA_W  upstream payload
- out_valid_o  output  1  downstream beat present
- out_ready_i  input  1  downstream accepts
- out_data_o  output  DATA_W  downstream payload
- occ_o  output  2  beats held: 0..2 with skid, 0..1 without

## Operation
- Accept = in_valid_i & in_ready_o. Send = out_valid_o & out_ready_i.
- Main entry drives out_valid_o/out_data_o. Skid entry exists only with the macro.
- Per rising edge, in priority order:
  - flush_i=1: main and skid valids cleared; data regs set to RESET_DATA. A beat accepted in the same cycle is dropped.
  - Main empty or Send: main loads skid if skid valid (skid clears), else loads input on Accept, else goes invalid (bubble).
  - Main full, no Send, Accept: input goes to skid (skid build only).
  - Otherwise: hold. out_data_o stays stable while out_valid_o=1 and out_ready_i=0.
- No beat is lost or duplicated outside flush. Order is FIFO.
- occ_o = main valid + skid valid.
- Data regs load only on the transfers above, never on idle cycles.

## Timing
- Reset (async assert, held until release): out_valid_o=0, out_data_o=RESET_DATA, skid empty, occ_o=0. in_ready_o=1.
- Latency: in_data_i accepted at edge N appears on out_data_o after edge N (1 cycle).
- Throughput: 1 beat/cycle with out_ready_i held high.
- Skid build: in_ready_o = !skid_valid, a registered signal with no combinational path from out_ready_i. Stall response:
  - first stalled cycle absorbs one extra beat;
  - in_ready_o drops the cycle after the skid fills;
  - in_ready_o rises the cycle after the skid drains.
- Full (occ_o=2) with Send: skid moves to main; in_ready_o=1 next cycle.
- Reset asserted mid-transfer: state cleared immediately. Any in-flight beat is lost.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry stage with skid; in_ready_o registered as above.
- Not defined:
  - single entry; in_ready_o = !out_valid_o | out_ready_i (combinational);
  - occ_o[1] tied 0;
  - same 1-cycle latency and full throughput;
  - no beat is absorbed while stalled.

## Structure
- Package pipe_pkg holds:
  - per-stage payload widths (PC_W=32, DATA_W32=32, RD_W=5);
  - packed struct typedefs if_id_t, id_ex_t, ex_mem_t, mem_wb_t;
  - the default width constants, e.g. MEM_WB_W=102 derived from $bits(mem_wb_t).
- One sub-module: pipe_entry. It is a single valid+data register with load/clear/flush inputs, instantiated as main and, under the macro, as skid.

## Test plan
- Reset release, in_valid_i=0 → out_valid_o=0, out_data_o=0, occ_o=0, in_ready_o=1.
- Stream 0x1..0x8, out_ready_i=1 → each value on out_data_o one cycle after accept, 8 consecutive valid cycles, no gaps.
- Send 0xA, 0xB with out_ready_i=0 (skid build) → occ_o=2, in_ready_o=0, out_data_o=0xA stable. Raise out_ready_i → 0xA then 0xB out; in_ready_o=1 one cycle after the skid drains.
- Same stall without macro → 0xB not accepted while stalled (in_ready_o=0). 0xB is accepted the cycle out_ready_i rises.
- Occupancy 2 plus in_valid_i=1, data 0xC, with flush_i=1 → next cycle occ_o=0, out_valid_o=0, 0xC never appears on output.
- Assert rst_i low mid-stream with occ_o=1 → out_valid_o=0 and out_data_o=RESET_DATA without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: per-stage payload layouts and widths for pipe_stage instances.
package pipe_pkg;
    localparam int PC_W     = 32;
    localparam int DATA_W32 = 32;
    localparam int RD_W     = 5;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [DATA_W32-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [DATA_W32-1:0] rs1_val;
        logic [DATA_W32-1:0] rs2_val;
        logic [DATA_W32-1:0] imm;
        logic [RD_W-1:0]     rd;
        logic [7:0]          ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [DATA_W32-1:0] alu;
        logic [DATA_W32-1:0] rs2_val;
        logic [RD_W-1:0]     rd;
        logic [2:0]          ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [DATA_W32-1:0] alu;
        logic [DATA_W32-1:0] rdata;
        logic [RD_W-1:0]     rd;
        logic                wb;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+data register; flush beats load, load beats clear.
module pipe_entry #(
    parameter int                DATA_W     = 102,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            data_o  <= RESET_DATA;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            data_o  <= RESET_DATA;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= d_i;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with flush.
// Define PIPE_STAGE_SKID_EN for a two-entry stage with registered in_ready_o.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = MEM_WB_W,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);
    logic              main_adv;
    logic              accept;
    logic              m_load;
    logic [DATA_W-1:0] m_d;

    // main may take a new beat whenever it is empty or its beat leaves now
    assign main_adv = !out_valid_o | out_ready_i;
    assign accept   = in_valid_i & in_ready_o;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [DATA_W-1:0] s_data;

    assign in_ready_o = !s_valid;
    assign m_load     = main_adv & (s_valid | accept);
    assign m_d        = s_valid ? s_data : in_data_i;
    assign occ_o      = {1'b0, out_valid_o} + {1'b0, s_valid};

    pipe_entry #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (!main_adv & accept),
        .clear_i (main_adv),
        .d_i     (in_data_i),
        .valid_o (s_valid),
        .data_o  (s_data)
    );
`else
    assign in_ready_o = main_adv;
    assign m_load     = accept;
    assign m_d        = in_data_i;
    assign occ_o      = {1'b0, out_valid_o};
`endif

    pipe_entry #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (m_load),
        .clear_i (main_adv),
        .d_i     (m_d),
        .valid_o (out_valid_o),
        .data_o  (out_data_o)
    );
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed self-checking bench for pipe_stage (either build of PIPE_STAGE_SKID_EN).
module tb_pipe_stage;
    localparam int W = 102;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] in_data_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] out_data_o;
    logic [1:0]   occ_o;
    int           errors = 0;
    int           checks = 0;

    pipe_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occ_o       (occ_o)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        #3;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
        checks++; if (out_data_o !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data_o); end
        checks++; if (occ_o !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ_o); end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", out_valid_o); end
    endtask

    task automatic test_stream;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = W'(1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++; if (out_valid_o !== 1'b1 || out_data_o !== W'(i)) begin errors++; $display("FAIL stream_%0d: got v=%b d=%0h expected v=1 d=%0h", i, out_valid_o, out_data_o, i); end
            checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready_o); end
            in_data_i  = W'(i + 1);
            in_valid_i = (i < 8);
        end
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occ_o); end
    endtask

    task automatic test_stall;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = W'('hA);
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== W'('hA)) begin errors++; $display("FAIL stall_a: got v=%b d=%0h expected v=1 d=a", out_valid_o, out_data_o); end
        in_data_i = W'('hB);
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (occ_o !== 2'd2 || in_ready_o !== 1'b0) begin errors++; $display("FAIL skid_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occ_o, in_ready_o); end
        in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (out_data_o !== W'('hA) || occ_o !== 2'd2) begin errors++; $display("FAIL skid_hold: got d=%0h occ=%0d expected d=a occ=2", out_data_o, occ_o); end
        out_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (out_data_o !== W'('hB) || occ_o !== 2'd1 || in_ready_o !== 1'b1) begin errors++; $display("FAIL skid_drain: got d=%0h occ=%0d rdy=%b expected d=b occ=1 rdy=1", out_data_o, occ_o, in_ready_o); end
`else
        checks++; if (occ_o !== 2'd1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL nskid_stall: got occ=%0d rdy=%b expected occ=1 rdy=0", occ_o, in_ready_o); end
        @(negedge clk);
        checks++; if (out_data_o !== W'('hA) || occ_o !== 2'd1) begin errors++; $display("FAIL nskid_hold: got d=%0h occ=%0d expected d=a occ=1", out_data_o, occ_o); end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL nskid_comb_ready: got %b expected 1", in_ready_o); end
        @(negedge clk);
        checks++; if (out_data_o !== W'('hB) || out_valid_o !== 1'b1) begin errors++; $display("FAIL nskid_b: got v=%b d=%0h expected v=1 d=b", out_valid_o, out_data_o); end
        in_valid_i = 1'b0;
`endif
        @(negedge clk);
        checks++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin errors++; $display("FAIL stall_empty: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occ_o); end
    endtask

    task automatic test_flush;
        logic saw_c;
        saw_c       = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = W'('hA);
        @(negedge clk);
        in_data_i = W'('hB);
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (occ_o !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 2", occ_o); end
`else
        checks++; if (occ_o !== 2'd1) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 1", occ_o); end
        out_ready_i = 1'b1;
`endif
        in_data_i = W'('hC);
        flush_i   = 1'b1;
        @(negedge clk);
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        checks++; if (occ_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== '0) begin errors++; $display("FAIL flush_clear: got occ=%0d v=%b d=%0h expected occ=0 v=0 d=0", occ_o, out_valid_o, out_data_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid_o && out_data_o === W'('hC)) saw_c = 1'b1;
        end
        checks++; if (saw_c !== 1'b0) begin errors++; $display("FAIL flush_drop_c: got seen=%b expected 0", saw_c); end
    endtask

    task automatic test_async_reset;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = W'('h55);
        @(negedge clk);
        in_valid_i = 1'b0;
        checks++; if (occ_o !== 2'd1 || out_data_o !== W'('h55)) begin errors++; $display("FAIL areset_pre: got occ=%0d d=%0h expected occ=1 d=55", occ_o, out_data_o); end
        #1 rst_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || out_data_o !== '0 || occ_o !== 2'd0) begin errors++; $display("FAIL areset_clear: got v=%b d=%0h occ=%0d expected v=0 d=0 occ=0", out_valid_o, out_data_o, occ_o); end
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
